// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port-per-direction memory: CPU (0) and debug (1).
// Round-robin between requesters, debug lock override, and a two-stage read return path.
module mem_arbiter #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDRESS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_req,
  input  logic [1:0]              i_we,
  input  logic [2*NB_ADDRESS-1:0] i_addr,
  input  logic [2*NB_DATA-1:0]    i_wdata,
  input  logic                    i_lock,
  output logic [1:0]              o_gnt,
  output logic [1:0]              o_rvalid,
  output logic [2*NB_DATA-1:0]    o_rdata,
  output logic [NB_ADDRESS-1:0]   o_mem_r_addr,
  output logic                    o_mem_r_en,
  output logic [NB_ADDRESS-1:0]   o_mem_w_addr,
  output logic [NB_DATA-1:0]      o_mem_w_data,
  output logic                    o_mem_w_en,
  input  logic [NB_DATA-1:0]      i_mem_r_data
);

  localparam logic [1:0] ST_PRIO0 = 2'd0;
  localparam logic [1:0] ST_PRIO1 = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            gnt;
  logic                  sel;
  logic                  granted;
  logic                  gnt_we;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [NB_DATA-1:0]    rdata_q [2];
  logic [NB_DATA-1:0]    rdata_d [2];
  logic [NB_ADDRESS-1:0] addr_s  [2];
  logic [NB_DATA-1:0]    wdata_s [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      assign addr_s[gi]  = i_addr[gi*NB_ADDRESS +: NB_ADDRESS];
      assign wdata_s[gi] = i_wdata[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

  // Lock is honoured combinationally so the CPU is blocked in the very cycle lock rises.
  always_comb begin
    gnt = 2'b00;
    if (i_rst_n) begin
      if (i_lock || state_q == ST_LOCK) begin
        gnt[1] = i_req[1];
      end else if (state_q == ST_PRIO1) begin
        if (i_req[1])      gnt = 2'b10;
        else if (i_req[0]) gnt = 2'b01;
      end else begin
        if (i_req[0])      gnt = 2'b01;
        else if (i_req[1]) gnt = 2'b10;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_lock)                 state_d = ST_LOCK;
    else if (state_q == ST_LOCK) state_d = ST_PRIO0;
    else if (gnt[0])            state_d = ST_PRIO1;
    else if (gnt[1])            state_d = ST_PRIO0;
  end

  assign sel          = gnt[1];
  assign granted      = |gnt;
  assign gnt_we       = sel ? i_we[1] : i_we[0];
  assign o_gnt        = gnt;
  assign o_mem_r_en   = granted & ~gnt_we;
  assign o_mem_w_en   = granted & gnt_we;
  assign o_mem_r_addr = addr_s[sel];
  assign o_mem_w_addr = addr_s[sel];
  assign o_mem_w_data = wdata_s[sel];

  // Memory answers one cycle after the read edge; the owner tag travels alongside.
  assign rd_pend_d  = o_mem_r_en;
  assign rd_owner_d = sel;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      always_comb begin
        rdata_d[gi]  = rdata_q[gi];
        rvalid_d[gi] = 1'b0;
        if (rd_pend_q && rd_owner_q == 1'(gi)) begin
          rdata_d[gi]  = i_mem_r_data;
          rvalid_d[gi] = 1'b1;
        end
      end
      assign o_rdata[gi*NB_DATA +: NB_DATA] = rdata_q[gi];
    end
  endgenerate

  assign o_rvalid = rvalid_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_PRIO0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rvalid_q   <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rvalid_q   <= rvalid_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

endmodule
